// File: rtl/mx_ctrl_pkg.sv
// MX dot-product control package: sequencer state encoding and the
// width helpers shared by the sequencer and the post-scale stage.
package mx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mx_seq_state_t;

    // Fixed-point product width of mul_fp for one element pair.
    function automatic int mx_prd_width(input int exp_width,
                                        input int man_width);
        return 2 * ((1 << exp_width) + man_width);
    endfunction

    // Accumulator width that cannot overflow over k products.
    function automatic int mx_acc_width(input int exp_width,
                                        input int man_width,
                                        input int k);
        return mx_prd_width(exp_width, man_width) + $clog2(k);
    endfunction

endpackage

// File: rtl/mx_dot_seq_if.sv
// Element/result handshake bundle of the MX dot-product sequencer.
// master: operand-buffer / consumer side, slave: the sequencer.
interface mx_dot_seq_if #(
    parameter int bit_width   = 8,
    parameter int scale_width = 8,
    parameter int acc_width   = 73
);
    logic                        i_start;
    logic [scale_width-1:0]      i_scale0;
    logic [scale_width-1:0]      i_scale1;
    logic                        o_busy;
    logic                        i_el_valid;
    logic                        o_el_ready;
    logic [bit_width-1:0]        i_op0;
    logic [bit_width-1:0]        i_op1;
    logic                        o_res_valid;
    logic                        i_res_ready;
    logic signed [acc_width-1:0] o_acc;
    logic [scale_width:0]        o_scale_sum;

    modport master (
        output i_start, i_scale0, i_scale1,
        output i_el_valid, i_op0, i_op1, i_res_ready,
        input  o_busy, o_el_ready, o_res_valid,
        input  o_acc, o_scale_sum
    );

    modport slave (
        input  i_start, i_scale0, i_scale1,
        input  i_el_valid, i_op0, i_op1, i_res_ready,
        output o_busy, o_el_ready, o_res_valid,
        output o_acc, o_scale_sum
    );
endinterface

// File: rtl/mul_fp.sv
// Combinational MX element multiplier: two sign/exp/man elements in,
// exact signed fixed-point product out (LSB = 2^-2m of unit scale).
module mul_fp
    import mx_ctrl_pkg::*;
#(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int prd_width = mx_prd_width(exp_width, man_width),
    localparam int mag_width = prd_width / 2
) (
    input  logic [bit_width-1:0]        i_op0,
    input  logic [bit_width-1:0]        i_op1,
    output logic signed [prd_width-1:0] o_prd
);

    // Subnormals (exp 0) share the exp-1 shift with an implicit 0.
    function automatic logic [mag_width-1:0] fx_mag(
        input logic [bit_width-1:0] op
    );
        logic [exp_width-1:0] e;
        logic [exp_width-1:0] sh;
        logic [mag_width-1:0] m;
        e  = op[bit_width-2 -: exp_width];
        sh = (e == '0) ? '0 : e - 1'b1;
        m  = mag_width'({(e != '0), op[man_width-1:0]});
        return m << sh;
    endfunction

    logic [prd_width-1:0] mag;
    logic                 neg;

    always_comb begin
        mag   = prd_width'(fx_mag(i_op0)) * prd_width'(fx_mag(i_op1));
        neg   = i_op0[bit_width-1] ^ i_op1[bit_width-1];
        o_prd = neg ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/mx_dot_seq.sv
// Streams one MX block of k element pairs through mul_fp and sums the
// products; clk/rst plain ports, handshakes on the mx_dot_seq_if slave.
module mx_dot_seq
    import mx_ctrl_pkg::*;
#(
    parameter int exp_width   = 5,
    parameter int man_width   = 2,
    parameter int k           = 32,
    parameter int scale_width = 8,
    localparam int prd_width  = mx_prd_width(exp_width, man_width),
    localparam int acc_width  = mx_acc_width(exp_width, man_width, k)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mx_dot_seq_if.slave bus
);

    localparam int cnt_width = $clog2(k);

    mx_seq_state_t               state_q, state_d;
    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic signed [prd_width-1:0] prd_q, prd_d, prd_w;
    logic                        prd_vld_q, prd_vld_d;
    logic signed [acc_width-1:0] acc_q, acc_d;
    logic [scale_width:0]        ssum_q, ssum_d;
    logic                        busy_q, busy_d;
    logic                        el_ready_q, el_ready_d;
    logic                        res_valid_q, res_valid_d;
    logic                        accept;

    mul_fp #(
        .exp_width (exp_width),
        .man_width (man_width)
    ) u_mul_fp (
        .i_op0 (bus.i_op0),
        .i_op1 (bus.i_op1),
        .o_prd (prd_w)
    );

    assign accept = bus.i_el_valid & el_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prd_d     = prd_q;
        prd_vld_d = 1'b0;
        acc_d     = acc_q;
        ssum_d    = ssum_q;
        if (prd_vld_q) begin
            acc_d = acc_q + {{(acc_width-prd_width){prd_q[prd_width-1]}},
                             prd_q};
        end
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ssum_d  = {1'b0, bus.i_scale0} + {1'b0, bus.i_scale1};
                end
            end
            RUN: begin
                if (accept) begin
                    prd_d     = prd_w;
                    prd_vld_d = 1'b1;
                    // Hold the count at k-1 so it never wraps.
                    if (cnt_q == cnt_width'(k - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        el_ready_d  = (state_d == RUN);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prd_q       <= '0;
            prd_vld_q   <= 1'b0;
            acc_q       <= '0;
            ssum_q      <= '0;
            busy_q      <= 1'b0;
            el_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prd_q       <= prd_d;
            prd_vld_q   <= prd_vld_d;
            acc_q       <= acc_d;
            ssum_q      <= ssum_d;
            busy_q      <= busy_d;
            el_ready_q  <= el_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_el_ready  = el_ready_q;
    assign bus.o_res_valid = res_valid_q;
    assign bus.o_acc       = acc_q;
    assign bus.o_scale_sum = ssum_q;

endmodule
